// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/DIV controller that owns the HI/LO registers.
// A countdown register doubles as the IDLE/BUSY state (IDLE when it is zero).
// The result is computed from the latched operands and committed to HI/LO on
// the final busy edge. The stall output freezes Decode while a HI/LO consumer
// would otherwise read stale data.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] L_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] L_DIV  = CW'(DIV_CYCLES);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    logic [CW-1:0] r_cnt, w_cnt_nxt;
    op_e           r_op,  w_op_nxt;
    logic [31:0]   r_a,   w_a_nxt;
    logic [31:0]   r_b,   w_b_nxt;
    logic [31:0]   r_hi,  w_hi_nxt;
    logic [31:0]   r_lo,  w_lo_nxt;

    // Arithmetic on the latched operands; only sampled on the commit edge.
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_divisor_u, w_mag_a, w_mag_b, w_q_mag, w_r_mag;
    logic [31:0] w_q_s, w_r_s, w_q_u, w_r_u;
    logic [31:0] w_res_hi, w_res_lo;
    logic        w_res_write;

    assign w_prod_s    = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u    = {32'd0, r_a} * {32'd0, r_b};
    assign w_div_zero  = (r_b == 32'd0);
    // A zero divisor is replaced by 1 so the divider never sees 0; the result is discarded anyway.
    assign w_divisor_u = w_div_zero ? 32'd1 : r_b;
    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign w_mag_a     = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_mag_b     = r_b[31] ? (~r_b + 32'd1) : w_divisor_u;
    assign w_q_mag     = w_mag_a / w_mag_b;
    assign w_r_mag     = w_mag_a % w_mag_b;
    assign w_q_s       = (r_a[31] ^ r_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s       = r_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_q_u       = r_a / w_divisor_u;
    assign w_r_u       = r_a % w_divisor_u;

    // Select the committed result for the latched op; divides by zero leave HI/LO alone.
    always_comb begin
        w_res_hi    = r_hi;
        w_res_lo    = r_lo;
        w_res_write = 1'b1;
        case (r_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV:   begin w_res_hi = w_r_s; w_res_lo = w_q_s; w_res_write = ~w_div_zero; end
            OP_DIVU:  begin w_res_hi = w_r_u; w_res_lo = w_q_u; w_res_write = ~w_div_zero; end
            default:  w_res_write = 1'b0;
        endcase
    end

    // State register: counter, latched operation and HI/LO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_cnt <= '0;
            r_op  <= OP_MULT;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_op  <= w_op_nxt;
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    // Next state: count down while busy and commit on the last count; accept only when idle.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path infers a latch.
        w_cnt_nxt = r_cnt;
        w_op_nxt  = r_op;
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_hi_nxt  = r_hi;
        w_lo_nxt  = r_lo;
        if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CW'(1) && w_res_write) begin
                w_hi_nxt = w_res_hi;
                w_lo_nxt = w_res_lo;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    w_op_nxt  = op_e'(op);
                    w_a_nxt   = a;
                    w_b_nxt   = b;
                    w_cnt_nxt = L_MULT;
                end
                OP_DIV, OP_DIVU: begin
                    w_op_nxt  = op_e'(op);
                    w_a_nxt   = a;
                    w_b_nxt   = b;
                    w_cnt_nxt = L_DIV;
                end
                OP_MTHI: w_hi_nxt = a;
                OP_MTLO: w_lo_nxt = a;
                default: ;
            endcase
        end
    end

    // Outputs: busy from the counter, stall is zero-latency on md_use/busy/start.
    always_comb begin
        busy  = (r_cnt != '0);
        stall = md_use & ((r_cnt != '0) | start);
        hi    = r_hi;
        lo    = r_lo;
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level reference model
// that tracks the cycle on which each pending result becomes visible.
module tb_mdu_sequencer;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst, start, md_use;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo;

    mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: cycle index, cycle at which the pending result appears.
    int          cyc;
    int          m_done;
    logic        m_pend;
    logic        m_pend_ok;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    function automatic void compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic ok, output logic [31:0] h, output logic [31:0] l);
        longint          sp, sx, sy, q, r;
        longint unsigned up;
        ok = 1'b1; h = 32'd0; l = 32'd0;
        case (o)
            MULT:  begin sp = longint'($signed(x)) * longint'($signed(y)); h = sp[63:32]; l = sp[31:0]; end
            MULTU: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
            DIV: begin
                if (y == 32'd0) ok = 1'b0;
                else begin
                    sx = longint'($signed(x)); sy = longint'($signed(y));
                    q = sx / sy; r = sx % sy;
                    l = q[31:0]; h = r[31:0];
                end
            end
            DIVU: begin
                if (y == 32'd0) ok = 1'b0;
                else begin l = x / y; h = x % y; end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic logic m_busy();
        return cyc < m_done;
    endfunction

    task automatic model_reset();
        m_done = 0; m_pend = 1'b0; m_pend_ok = 1'b0;
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    endtask

    // Apply the rules for the edge that ends cycle 'cyc'.
    task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic r);
        logic        was_busy, ok;
        logic [31:0] h, l;
        if (r) model_reset();
        else begin
            was_busy = m_busy();
            if (m_pend && cyc + 1 == m_done) begin
                if (m_pend_ok) begin m_hi = m_phi; m_lo = m_plo; end
                m_pend = 1'b0;
            end
            if (s && !was_busy) begin
                case (o)
                    MULT, MULTU, DIV, DIVU: begin
                        compute(o, x, y, ok, h, l);
                        m_pend = 1'b1; m_pend_ok = ok; m_phi = h; m_plo = l;
                        m_done = cyc + 1 + ((o == MULT || o == MULTU) ? MULT_N : DIV_N);
                    end
                    MTHI: m_hi = x;
                    MTLO: m_lo = x;
                    default: ;
                endcase
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model.
    task automatic tick(input logic s, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic md, input logic r);
        start = s; op = o; a = x; b = y; md_use = md; rst = r;
        @(negedge clk);
        check("busy",  {31'd0, busy},  {31'd0, m_busy()});
        check("stall", {31'd0, stall}, {31'd0, md & (m_busy() | s)});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        @(posedge clk);
        model_edge(s, o, x, y, r);
        #1;
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 32'd0, 32'd0, md, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        model_reset();
        idle(1, 1'b1);

        // Signed MULT, stall held by a waiting MFLO through the busy window.
        tick(1'b1, MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        idle(MULT_N, 1'b1);
        idle(1, 1'b1);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);

        // Unsigned MULT, no HI/LO consumer in Decode.
        tick(1'b1, MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        idle(MULT_N, 1'b0);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // Signed DIV -7 / 2.
        tick(1'b1, DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // MTHI then MTLO back to back.
        tick(1'b1, MTHI, 32'h12345678, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", hi, 32'h12345678);
        tick(1'b1, MTLO, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b0);
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        idle(2, 1'b0);

        // DIVU by zero keeps preloaded HI/LO.
        tick(1'b1, MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
        tick(1'b1, MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
        tick(1'b1, DIVU, 32'h1234, 32'd0, 1'b0, 1'b0);
        idle(DIV_N + 1, 1'b0);
        check("divz_hi", hi, 32'h11);
        check("divz_lo", lo, 32'h22);

        // Signed overflow case.
        tick(1'b1, DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h00000000);

        // Second start during busy is ignored.
        tick(1'b1, MULT, 32'd7, 32'd6, 1'b0, 1'b0);
        idle(2, 1'b0);
        tick(1'b1, DIV, 32'd100, 32'd3, 1'b1, 1'b0);
        idle(MULT_N - 3, 1'b0);
        check("ign_lo", lo, 32'd42);
        check("ign_busy", {31'd0, busy}, 32'd0);

        // Reset during busy cycle 3 of a DIV, then a new MULT right away.
        tick(1'b1, DIV, 32'd50, 32'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rst_lo", lo, 32'd0);
        tick(1'b1, MULTU, 32'd3, 32'd5, 1'b0, 1'b0);
        idle(DIV_N + 2, 1'b0);
        check("post_rst_lo", lo, 32'd15);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic        s, md, r;
            logic [2:0]  o;
            logic [31:0] x, y;
            s  = ($urandom_range(0, 9) < 4);
            md = $urandom_range(0, 1) == 1;
            r  = ($urandom_range(0, 99) == 0);
            o  = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFFFFFF;
                2: x = 32'h80000000;
                3: y = y >> $urandom_range(8, 31);
                default: ;
            endcase
            tick(s, o, x, y, md, r);
        end
        idle(DIV_N + 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide controller for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations issued from the Execute stage and owns the architectural HI/LO registers. It sequences the fixed-latency operation with an internal countdown and raises the busy/stall signals that freeze Decode while any HI/LO consumer would otherwise read stale data. It sits beside the ALU in Execute; its HI/LO outputs feed the MFHI/MFLO path that rides the Memory/Writeback pipeline registers.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (must be ≥1)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (must be ≥1)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  Execute holds a valid HI/LO-class op this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved (no effect)
- a  input  32  operand rs (MTHI/MTLO source)
- b  input  32  operand rt
- md_use  input  1  Decode instruction is HI/LO-class (mult/div/mfhi/mflo/mthi/mtlo)
- busy  output  1  operation in progress
- stall  output  1  freeze Decode/Fetch, bubble into Execute
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE (cnt==0), BUSY (cnt!=0). busy = (cnt != 0), registered counter, width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Accept condition: start & ~busy. start while busy is ignored entirely; the pipeline guarantees this does not occur via stall.
- Accepted MULT/MULTU/DIV/DIVU: latch operands/op, load cnt with MULT_CYCLES or DIV_CYCLES.
- BUSY: cnt decrements each edge. On the edge where cnt==1: commit result to hi/lo, cnt→0.
- MULT: signed 32×32→64, {hi,lo} = a*b. MULTU: unsigned likewise.
- DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend. DIVU: unsigned.
- Divide-by-zero (b==0): busy sequence runs normally, hi/lo unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (no trap).
- MTHI/MTLO accepted: hi (resp. lo) ← a on the next edge; no busy cycles; the other register is untouched.
- Reserved op with start: no state change.
- stall = md_use & (busy | start), combinational. Non-HI/LO instructions never stall on this block.
- Reset: cnt 0, busy 0, hi 0, lo 0, latched operands 0. Reset mid-operation abandons the op; no commit occurs.

## Timing
- start sampled at edge E0 (cycle T): busy is high in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES), low in T+N+1.
- hi/lo show the new result from cycle T+N+1 (same cycle busy falls); previous values are held through T+N.
- A new MULT/DIV with start in cycle T+N+1 is accepted (back-to-back, no dead cycle).
- MTHI/MTLO with start in cycle T: new value visible in cycle T+1.
- stall has zero latency from md_use/busy/start; it is asserted in cycle T if Decode holds an MFLO while Execute starts the op, and stays asserted through T+N.
- rst asserted in any cycle forces reset values from the next cycle, overriding start.

## Test plan
- Reset, then MULT a=0xFFFFFFFF b=2 → busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged during busy.
- MULTU a=0xFFFFFFFF b=2 → hi=0x00000001, lo=0xFFFFFFFE; DIV a=0xFFFFFFF9 (−7) b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi=0x12345678 from the first cycle after, lo=0x9ABCDEF0 from the next; busy never rises.
- DIVU b=0 with hi=0x11, lo=0x22 preloaded → 10 busy cycles, hi=0x11, lo=0x22 retained; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- md_use=1 with MULT starting → stall high in the start cycle plus 5 busy cycles, then low; md_use=0 during busy → stall low; second start during busy ignored (cnt not reloaded, result from the first op).
- rst pulsed at busy cycle 3 of a DIV → busy=0, hi=lo=0 next cycle, no later commit; a new MULT accepted immediately after.
